// File: rtl/fault_mem_mbist_ctrl_if.sv
// Memory-side bus of the MBIST controller: write strobe, address, write data, read data.
interface fault_mem_mbist_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  write_read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output write_read, address, wdata, input rdata);
  modport slave  (input write_read, address, wdata, output rdata);
endinterface

// File: rtl/fault_mem_mbist_ctrl.sv
// March C- memory BIST controller: walks six March elements over 0..LAST_ADDR,
// counts miscompares and latches the first failing address/element/data.
module fault_mem_mbist_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LAST_ADDR  = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  fault_mem_mbist_ctrl_if.master mem,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [ADDR_WIDTH-1:0]  fail_addr,
  output logic [2:0]             fail_elem,
  output logic [DATA_WIDTH-1:0]  fail_data,
  output logic [7:0]             err_cnt
);
  typedef enum logic [2:0] {IDLE, SETUP, WRITE, READ, WAIT, CMP, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);

  state_t                state, state_n;
  logic [2:0]            elem, elem_n, elem_nx;
  logic [ADDR_WIDTH-1:0] addr, addr_n, addr_step;
  logic [DATA_WIDTH-1:0] wd, wd_n;
  logic                  clr, step, last_a, miscmp;

  function automatic logic is_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] wr_val(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? '1 : '0;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rd_val(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? '1 : '0;
  endfunction

  assign elem_nx   = elem + 3'd1;
  assign last_a    = is_down(elem) ? (addr == '0) : (addr == LAST);
  assign addr_step = is_down(elem) ? addr - 1'b1 : addr + 1'b1;
  // An address is finished after its write, or after its compare in the read-only M5
  assign step      = (state == WRITE) || ((state == CMP) && (elem == 3'd5));
  assign miscmp    = (state == CMP) && (mem.rdata != rd_val(elem));

  always_comb begin
    state_n = state;
    elem_n  = elem;
    addr_n  = addr;
    wd_n    = wd;
    clr     = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_n = SETUP;
        elem_n  = '0;
        addr_n  = '0;
        wd_n    = wr_val(3'd0);
        clr     = 1'b1;
      end
      SETUP:   state_n = (elem == 3'd0) ? WRITE : READ;
      READ:    state_n = WAIT;
      WAIT:    state_n = CMP;
      CMP:     state_n = WRITE;
      WRITE:   state_n = WRITE;
      default: state_n = IDLE;
    endcase
    if (step) begin
      if (!last_a) begin
        addr_n  = addr_step;
        state_n = (elem == 3'd0) ? WRITE : READ;
      end else if (elem == 3'd5) begin
        state_n = DONE;
      end else begin
        // wdata is loaded here so it is already stable in SETUP, ahead of the first write
        state_n = SETUP;
        elem_n  = elem_nx;
        addr_n  = is_down(elem_nx) ? LAST : '0;
        wd_n    = wr_val(elem_nx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      elem  <= '0;
      addr  <= '0;
      wd    <= '0;
    end else begin
      state <= state_n;
      elem  <= elem_n;
      addr  <= addr_n;
      wd    <= wd_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
      err_cnt   <= '0;
    end else if (clr) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
      err_cnt   <= '0;
    end else if (miscmp) begin
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (!fail) begin
        fail      <= 1'b1;
        fail_addr <= addr;
        fail_elem <= elem;
        fail_data <= mem.rdata;
      end
    end
  end

  assign mem.write_read = (state == WRITE);
  assign mem.address    = addr;
  assign mem.wdata      = wd;
  assign busy           = (state != IDLE) && (state != DONE);
  assign done           = (state == DONE);
endmodule

// File: tb/tb_fault_mem_mbist_ctrl.sv
// Bench for the March C- controller: faulty memory model, March trace/result model
// built from the algorithm, and one per-cycle compare process.
module tb_fault_mem_mbist_ctrl;
  localparam int DW = 8, AW = 4, LA = 15, N = LA + 1, RUN_LEN = 6 + 20 * N;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_data;
  logic [7:0]    err_cnt;

  fault_mem_mbist_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fault_mem_mbist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LAST_ADDR(LA)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem(bus.master),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .fail_elem(fail_elem), .fail_data(fail_data), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // memory with one optional stuck-at cell; write uses last cycle's wdata, read latency 2
  int            fa;
  logic [DW-1:0] s1, s0;
  logic [DW-1:0] mem [N];
  logic [DW-1:0] wd_d, rd1;

  function automatic logic [DW-1:0] faulty(input int a, input logic [DW-1:0] v);
    return (a == fa) ? ((v | s1) & ~s0) : v;
  endfunction

  always @(posedge clk) begin
    wd_d <= bus.wdata;
    if (bus.write_read) mem[bus.address] <= wd_d;
    rd1       <= faulty(int'(bus.address), mem[bus.address]);
    bus.rdata <= rd1;
  end

  // model: expected per-cycle bus trace and final results
  logic          exp_wr [$];
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_wd [$];
  logic          m_fail;
  logic [AW-1:0] m_addr;
  logic [2:0]    m_elem;
  logic [DW-1:0] m_data;
  int            m_err;
  logic          l_fail;
  logic [AW-1:0] l_addr;
  logic [2:0]    l_elem;
  logic [DW-1:0] l_data;
  int            l_err;

  task automatic push(input logic w, input int a, input logic [DW-1:0] d);
    exp_wr.push_back(w);
    exp_addr.push_back(AW'(a));
    exp_wd.push_back(d);
  endtask

  task automatic build_model();
    logic [DW-1:0] mm [N];
    logic [DW-1:0] wv, rv, v;
    bit dn;
    int a;
    exp_wr.delete(); exp_addr.delete(); exp_wd.delete();
    m_fail = 0; m_addr = '0; m_elem = '0; m_data = '0; m_err = 0;
    for (int e = 0; e < 6; e++) begin
      dn = (e == 3) || (e == 4);
      wv = (e == 1 || e == 3) ? '1 : '0;
      rv = (e == 2 || e == 4) ? '1 : '0;
      push(1'b0, dn ? LA : 0, wv);
      for (int i = 0; i < N; i++) begin
        a = dn ? LA - i : i;
        if (e != 0) begin
          repeat (3) push(1'b0, a, wv);
          v = faulty(a, mm[a]);
          if (v !== rv) begin
            if (m_err < 255) m_err++;
            if (!m_fail) begin
              m_fail = 1'b1; m_addr = AW'(a); m_elem = 3'(e); m_data = v;
            end
          end
        end
        if (e != 5) begin
          push(1'b1, a, wv);
          mm[a] = wv;
        end
      end
    end
  endtask

  // compare process
  int            pass = 0, total = 0;
  int            idx = 0, busy_cyc = 0, runs_done = 0, seen_arm = 0, arm_cnt = 0;
  bit            active = 0;
  logic [DW-1:0] prev_wd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act === expv) pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
  endtask

  always @(posedge clk or negedge rst_n) begin
    #1;
    if (!rst_n) begin
      active = 0;
      chk("reset_outputs", {bus.write_read, bus.address, bus.wdata, busy, done, fail,
                            fail_addr, fail_elem, fail_data, err_cnt}, 64'd0);
    end else if (active || arm_cnt != seen_arm) begin
      if (!active) begin
        active = 1; idx = 0; busy_cyc = 0; seen_arm = arm_cnt;
        chk("cleared_at_setup", {done, fail, fail_addr, fail_elem, fail_data, err_cnt}, 64'd0);
      end
      if (idx < exp_wr.size()) begin
        chk("write_read", bus.write_read, exp_wr[idx]);
        chk("address", bus.address, exp_addr[idx]);
        chk("busy", busy, 1'b1);
        if (exp_wr[idx]) begin
          chk("wdata_on_write", bus.wdata, exp_wd[idx]);
          chk("wdata_prior", prev_wd, exp_wd[idx]);
        end
        if (busy) busy_cyc++;
        idx++;
      end else begin
        chk("done", {done, busy, bus.write_read}, 3'b100);
        chk("fail", fail, m_fail);
        chk("fail_addr", fail_addr, m_addr);
        chk("fail_elem", fail_elem, m_elem);
        chk("fail_data", fail_data, m_data);
        chk("err_cnt", err_cnt, 64'(m_err));
        chk("busy_cycles", 64'(busy_cyc), 64'd326);
        chk("lit_result", {fail, fail_addr, fail_elem, fail_data, err_cnt},
            {l_fail, l_addr, l_elem, l_data, 8'(l_err)});
        active = 0;
        runs_done++;
      end
    end else begin
      chk("idle_no_write", {bus.write_read, busy}, 2'b00);
    end
    prev_wd = bus.wdata;
  end

  // driver
  task automatic wait_run(input int r);
    int c;
    c = 0;
    while (runs_done == r && c < RUN_LEN + 50) begin
      @(negedge clk);
      c++;
    end
    if (runs_done == r) begin
      $display("FAIL run_timeout: no done after %0d cycles", c);
      $display("%0d/%0d checks passed", pass, total + 1);
      $fatal(1, "timeout");
    end
  endtask

  task automatic do_run();
    int r;
    @(negedge clk);
    start = 1'b1; arm_cnt++; r = runs_done;
    @(negedge clk);
    start = 1'b0;
    wait_run(r);
  endtask

  task automatic set_case(input int a, input logic [DW-1:0] m1, input logic [DW-1:0] m0,
                          input logic lf, input int la, input int le,
                          input logic [DW-1:0] ld, input int lerr);
    fa = a; s1 = m1; s0 = m0;
    l_fail = lf; l_addr = AW'(la); l_elem = 3'(le); l_data = ld; l_err = lerr;
    build_model();
  endtask

  initial begin
    int r, c;
    rst_n = 1'b0; start = 1'b0; fa = -1; s1 = '0; s0 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // fault-free memory
    set_case(-1, 8'h00, 8'h00, 1'b0, 0, 0, 8'h00, 0);
    do_run();
    repeat (3) @(negedge clk);

    // address 5 bit 5 stuck-at-1
    set_case(5, 8'h20, 8'h00, 1'b1, 5, 1, 8'h20, 3);
    do_run();

    // address 15 bit 0 stuck-at-0
    set_case(15, 8'h00, 8'h01, 1'b1, 15, 2, 8'hFE, 2);
    do_run();

    // reset during M3, then a fresh run
    set_case(-1, 8'h00, 8'h00, 1'b0, 0, 0, 8'h00, 0);
    @(negedge clk);
    start = 1'b1; arm_cnt++;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (idx < 160 && c < RUN_LEN) begin
      @(negedge clk);
      c++;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    do_run();

    // start held high through a faulty run; second run begins straight from DONE
    set_case(5, 8'h20, 8'h00, 1'b1, 5, 1, 8'h20, 3);
    @(negedge clk);
    start = 1'b1; arm_cnt++; r = runs_done;
    wait_run(r);
    arm_cnt++; r = runs_done;
    @(negedge clk);
    start = 1'b0;
    wait_run(r);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/fault_mem_mbist_ctrl.md
FAULT_MEM_MBIST_CTRL -- requirements
Module: fault_mem_mbist_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, memory address width.
REQ-003 SHALL have parameter LAST_ADDR, default 15, highest tested address; tested range is 0..LAST_ADDR.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  begin test; sampled in IDLE or DONE.
REQ-007 SHALL have port write_read  output  1  to memory; 1 = write, 0 = read.
REQ-008 SHALL have port address  output  ADDR_WIDTH  to memory.
REQ-009 SHALL have port wdata  output  DATA_WIDTH  to memory.
REQ-010 SHALL have port rdata  input  DATA_WIDTH  from memory.
REQ-011 SHALL have port busy  output  1  test in progress.
REQ-012 SHALL have port done  output  1  test complete; held until next start.
REQ-013 SHALL have port fail  output  1  at least one miscompare seen in current or last run.
REQ-014 SHALL have port fail_addr  output  ADDR_WIDTH  address of first miscompare.
REQ-015 SHALL have port fail_elem  output  3  March element index (0..5) of first miscompare.
REQ-016 SHALL have port fail_data  output  DATA_WIDTH  rdata value at first miscompare.
REQ-017 SHALL have port err_cnt  output  8  number of miscompares, saturating at 255.

Function
REQ-018 SHALL execute March C-: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0); 0 = all-zeros word, 1 = all-ones word.
REQ-019 SHALL use FSM states IDLE, SETUP, WRITE, READ, WAIT, CMP, DONE.
REQ-020 SHALL move IDLE/DONE -> SETUP on start=1; start SHALL be ignored in all other states.
REQ-021 SHALL, on leaving IDLE/DONE, clear done, fail, fail_addr, fail_elem, fail_data and err_cnt, and assert busy from the SETUP cycle.
REQ-022 SHALL spend one SETUP cycle per element, with write_read=0, wdata set to the element's write value, and address set to the element's start address (0 for up, LAST_ADDR for down).
REQ-023 SHALL hold wdata constant for the entire element, because the memory applies the wdata presented one cycle before the write cycle.
REQ-024 SHALL, in WRITE, drive write_read=1 for exactly one cycle per address.
REQ-025 SHALL sequence read: READ (write_read=0, address=a) -> WAIT -> CMP; rdata is valid in CMP (two-cycle memory read latency); address SHALL stay at a through CMP.
REQ-026 SHALL, in CMP, compare rdata with the expected value (0 in M1/M3/M5, all-ones in M2/M4), then go to WRITE (M1-M4) or advance address (M5).
REQ-027 SHALL count a miscompare in err_cnt; on the first miscompare of a run only, it SHALL set fail=1 and latch fail_addr, fail_elem and fail_data.
REQ-028 SHALL never stop the test on a miscompare.
REQ-029 SHALL step address by +1 (up) or -1 (down) after the last operation at each address; after LAST_ADDR (up) or 0 (down) it SHALL enter SETUP of the next element, or DONE after M5, with no wrap-around.
REQ-030 SHALL take exactly 6+20*(LAST_ADDR+1) cycles from the first SETUP to the DONE entry: M0 1+N, M1-M4 1+4N each, M5 1+3N.
REQ-031 SHALL, in DONE, assert done=1 and busy=0, drive write_read=0, and hold all result outputs.

Reset
REQ-032 SHALL, while rst_n=0, force IDLE, write_read=0, address=0, wdata=0, busy=0, done=0, fail=0, fail_addr=0, fail_elem=0, fail_data=0 and err_cnt=0, regardless of clk.
REQ-033 SHALL, when reset is asserted mid-test, abort the test immediately; after rst_n rises it SHALL wait in IDLE for start.
REQ-034 SHALL in IDLE drive write_read=0 so the memory is never written.

Verification
REQ-035 SHALL cover: fault-free 16-word memory, start pulse -> busy for 326 cycles, then done=1, fail=0, err_cnt=0.
REQ-036 SHALL cover: bit 5 of address 5 stuck-at-1 -> fail=1, fail_elem=1, fail_addr=5, fail_data=8'h20, err_cnt=3.
REQ-037 SHALL cover: bit 0 of address 15 stuck-at-0 -> fail_elem=2, fail_addr=15, fail_data=8'hFE, err_cnt=2.
REQ-038 SHALL cover: rst_n low during M3 -> all outputs zero at once; no write seen after reset; a fresh start -> full 326-cycle run.
REQ-039 SHALL cover: start held high throughout the run -> ignored while busy; a new run begins from DONE with results cleared.
REQ-040 SHALL cover: protocol check on every write -> wdata equal on the write cycle and the prior cycle; down elements issue addresses 15..0 in order.
